// File: rtl/instruction_memory_pipelined.sv
// Pipelined instruction memory: registered read stage (S1), 2-entry response
// FIFO with valid/ready backpressure, flush for redirects, a word write port
// for program loading, and fault reporting for misaligned / out-of-range fetches.
module instruction_memory_pipelined #(
    parameter int          DEPTH     = 2048,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instruction,
    output logic [31:0] rsp_addr,
    output logic [1:0]  rsp_fault,
    input  logic        flush,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        wr_err
);

    localparam int          IDX     = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_W = DEPTH;

    typedef enum logic [1:0] {
        FAULT_OK       = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10
    } fault_e;

    // Program storage; contents deliberately survive reset_n.
    logic [31:0] mem [DEPTH];

    // Goes high on the first edge after reset so req_ready stays low in reset.
    logic        run;

    // S1 read stage
    logic        s1_valid;
    logic [31:0] s1_addr;
    logic [31:0] s1_data;
    fault_e      s1_fault;

    // Response FIFO
    logic [31:0] fifo_addr  [2];
    logic [31:0] fifo_data  [2];
    fault_e      fifo_fault [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    fault_e      req_fault;
    logic [1:0]  occupancy;
    logic        accept;
    logic        pop;
    logic        push;
    logic        wr_ok;

    // Fault classification of the incoming fetch address (misalignment wins).
    always_comb begin
        // NOTE: a default assignment first means every path drives req_fault, so no latch is inferred.
        req_fault = FAULT_OK;
        if (req_addr[1:0] != 2'b00)
            req_fault = FAULT_MISALIGN;
        else if ({2'b00, req_addr[31:2]} >= DEPTH_W)
            req_fault = FAULT_RANGE;
    end

    assign occupancy = {1'b0, s1_valid} + count;
    assign req_ready = run && !flush && (occupancy != 2'd3);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (count != 2'd0);
    assign pop       = rsp_valid && rsp_ready;
    assign push      = s1_valid && ((count != 2'd2) || pop);

    assign wr_ok = (wr_addr[1:0] == 2'b00) && ({2'b00, wr_addr[31:2]} < DEPTH_W);

    assign rsp_instruction = fifo_data[rd_ptr];
    assign rsp_addr        = fifo_addr[rd_ptr];
    assign rsp_fault       = fifo_fault[rd_ptr];

    // Run flag and write-reject pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run    <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            run    <= 1'b1;
            wr_err <= wr_en && !wr_ok;
        end
    end

    // Array write port; independent of the fetch handshake and of flush.
    // NOTE: the storage array has no reset branch -- program contents must outlive reset_n.
    always_ff @(posedge clk) begin
        if (wr_en && wr_ok)
            mem[wr_addr[IDX+1:2]] <= wr_data;
    end

    // S1: capture an accepted fetch (read-before-write on a same-edge write), else drain into the FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_data  <= '0;
            s1_fault <= FAULT_OK;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_addr  <= req_addr;
            s1_fault <= req_fault;
            s1_data  <= (req_fault == FAULT_OK) ? mem[req_addr[IDX+1:2]] : NOP_INSTR;
        end else if (push) begin
            s1_valid <= 1'b0;
        end
    end

    // Response FIFO: push from S1, pop by the consumer; flush empties it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_addr[i]  <= '0;
                fifo_data[i]  <= '0;
                fifo_fault[i] <= FAULT_OK;
            end
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_addr[wr_ptr]  <= s1_addr;
                fifo_data[wr_ptr]  <= s1_data;
                fifo_fault[wr_ptr] <= s1_fault;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_memory_pipelined.sv
// Scoreboard bench for instruction_memory_pipelined: the acceptance monitor
// pushes hand-computed expected responses, the response monitor pops and compares.
module tb_instruction_memory_pipelined;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instruction;
    logic [31:0] rsp_addr;
    logic [1:0]  rsp_fault;
    logic        flush;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_err;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [1:0]  fault;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_instr;
    logic [1:0]  exp_fault;
    int          total = 0;
    int          bad = 0;
    int          n_accept = 0;
    int          base;

    instruction_memory_pipelined #(.DEPTH(2048), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_instruction(rsp_instruction), .rsp_addr(rsp_addr), .rsp_fault(rsp_fault),
        .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare popped responses, record accepted requests, drop on flush/reset.
    always @(negedge clk) begin
        if (!reset_n) begin
            sb.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_instruction", rsp_instruction, e.instr);
                    check("rsp_addr", rsp_addr, e.addr);
                    check("rsp_fault", {30'd0, rsp_fault}, {30'd0, e.fault});
                end
            end
            if (req_valid && req_ready) begin
                sb.push_back('{addr: req_addr, instr: exp_instr, fault: exp_fault});
                n_accept++;
            end
            if (flush)
                sb.delete();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one fetch and hold it until accepted (bounded).
    task automatic send(input logic [31:0] a, input logic [31:0] ins, input logic [1:0] f);
        bit ok = 0;
        req_valid = 1'b1;
        req_addr  = a;
        exp_instr = ins;
        exp_fault = f;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("send_timeout", 32'd1, 32'd0);
        step();
        req_valid = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (sb.size() != 0 || rsp_valid); i++)
            step();
        check("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
        flush = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        exp_instr = '0; exp_fault = '0;
        #3;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_instruction", rsp_instruction, 32'd0);
        check("rst_rsp_addr", rsp_addr, 32'd0);
        check("rst_rsp_fault", {30'd0, rsp_fault}, 32'd0);
        check("rst_wr_err", {31'd0, wr_err}, 32'd0);
        step();
        reset_n = 1'b1;
        check("rel_req_ready_low", {31'd0, req_ready}, 32'd0);
        step();
        check("rel_req_ready_high", {31'd0, req_ready}, 32'd1);

        // Program load
        write_word(32'h00, 32'h2BC0_0093);
        write_word(32'h04, 32'h0180_9113);
        write_word(32'h08, 32'h0001_2193);
        write_word(32'h0C, 32'h0001_3213);
        write_word(32'h10, 32'h1111_1111);
        write_word(32'h40, 32'h0040_0513);
        check("load_wr_err", {31'd0, wr_err}, 32'd0);

        // Back-to-back fetch: 2-cycle latency, no gaps
        send(32'h0, 32'h2BC0_0093, 2'b00);
        check("b2b_valid_c1", {31'd0, rsp_valid}, 32'd0);
        send(32'h4, 32'h0180_9113, 2'b00);
        check("b2b_valid_c2", {31'd0, rsp_valid}, 32'd1);
        send(32'h8, 32'h0001_2193, 2'b00);
        check("b2b_valid_c3", {31'd0, rsp_valid}, 32'd1);
        send(32'hC, 32'h0001_3213, 2'b00);
        check("b2b_valid_c4", {31'd0, rsp_valid}, 32'd1);
        step();
        check("b2b_valid_c5", {31'd0, rsp_valid}, 32'd1);
        step();
        check("b2b_valid_c6", {31'd0, rsp_valid}, 32'd0);

        // Faults
        send(32'h0000_0002, NOP, 2'b01);
        send(32'h0000_2000, NOP, 2'b10);
        send(32'h0000_2002, NOP, 2'b01);
        send(32'h0000_1FFC, 32'hxxxx_xxxx, 2'b00);
        drain();

        // Backpressure: exactly 3 accepted with rsp_ready=0
        rsp_ready = 1'b0;
        base = n_accept;
        send(32'h0, 32'h2BC0_0093, 2'b00);
        send(32'h4, 32'h0180_9113, 2'b00);
        send(32'h8, 32'h0001_2193, 2'b00);
        req_valid = 1'b1; req_addr = 32'hC; exp_instr = 32'h0001_3213; exp_fault = 2'b00;
        repeat (3) begin
            @(negedge clk);
            check("bp_req_ready_low", {31'd0, req_ready}, 32'd0);
        end
        step();
        check("bp_accepted", n_accept - base, 32'd3);
        rsp_ready = 1'b1;
        send(32'hC, 32'h0001_3213, 2'b00);
        send(32'h10, 32'h1111_1111, 2'b00);
        drain();
        check("bp_total_accepted", n_accept - base, 32'd5);

        // Flush with 3 in flight
        rsp_ready = 1'b0;
        send(32'h0, 32'h2BC0_0093, 2'b00);
        send(32'h4, 32'h0180_9113, 2'b00);
        send(32'h8, 32'h0001_2193, 2'b00);
        base = n_accept;
        flush = 1'b1;
        req_valid = 1'b1; req_addr = 32'h40; exp_instr = 32'h0040_0513; exp_fault = 2'b00;
        @(negedge clk);
        check("flush_req_ready", {31'd0, req_ready}, 32'd0);
        step();
        flush = 1'b0;
        check("flush_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("flush_no_accept", n_accept - base, 32'd0);
        rsp_ready = 1'b1;
        send(32'h40, 32'h0040_0513, 2'b00);
        drain();

        // Read-during-write returns the old word; rejected write leaves memory alone
        wr_en = 1'b1; wr_addr = 32'h10; wr_data = 32'hDEAD_BEEF;
        send(32'h10, 32'h1111_1111, 2'b00);
        wr_en = 1'b0;
        check("rdw_wr_err", {31'd0, wr_err}, 32'd0);
        send(32'h10, 32'hDEAD_BEEF, 2'b00);
        write_word(32'h11, 32'h0000_0000);
        check("wr_err_pulse", {31'd0, wr_err}, 32'd1);
        step();
        check("wr_err_one_cycle", {31'd0, wr_err}, 32'd0);
        write_word(32'h0000_2000, 32'h0000_0000);
        check("wr_err_range", {31'd0, wr_err}, 32'd1);
        send(32'h10, 32'hDEAD_BEEF, 2'b00);
        drain();

        // Reset mid-stream with 2 buffered responses
        rsp_ready = 1'b0;
        send(32'h0, 32'h2BC0_0093, 2'b00);
        send(32'h4, 32'h0180_9113, 2'b00);
        step();
        check("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("mid_rst_rsp_instruction", rsp_instruction, 32'd0);
        check("mid_rst_rsp_addr", rsp_addr, 32'd0);
        step();
        step();
        reset_n = 1'b1;
        rsp_ready = 1'b1;
        step();
        check("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        send(32'h10, 32'hDEAD_BEEF, 2'b00);
        drain();

        check("final_scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_memory_pipelined.md
# instruction_memory_pipelined

Synchronous, parametrised instruction memory for the RV32I core. It replaces the combinational pc-indexed ROM with three things: a registered read stage, a 2-entry response buffer with valid/ready backpressure, and a flush for redirects. It also has a word write port for program loading from the debug interface, and reports misaligned and out-of-range fetch addresses instead of returning garbage. It sits between the PC/fetch stage and the IF/ID pipeline register.

## Interface
- DEPTH, 2048: memory size in 32-bit words. Power of two, 16..65536. IDX = log2(DEPTH).
- NOP_INSTR, 32'h0000_0013: instruction returned on a faulted fetch (ADDI x0,x0,0).
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  request accepted this cycle when req_valid && req_ready.
- req_addr  in  32  byte address of the fetch.
- rsp_valid  out  1  response at FIFO head.
- rsp_ready  in  1  consumer takes the response when rsp_valid && rsp_ready.
- rsp_instruction  out  32  fetched word, or NOP_INSTR on fault.
- rsp_addr  out  32  req_addr of this response.
- rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range.
- flush  in  1  discard all in-flight and buffered fetches.
- wr_en  in  1  program-load write strobe.
- wr_addr  in  32  byte address of the write.
- wr_data  in  32  word to write.
- wr_err  out  1  one-cycle pulse when a write is rejected.

## Operation
- Storage: DEPTH x 32 array. It is not reset; contents survive reset_n.
- Stage S1: one register holding valid, addr, fault and data.
  - On acceptance, S1 captures array[req_addr[IDX+1:2]] together with the computed fault.
- Response FIFO: 2 entries. S1 moves into the FIFO when the FIFO is not full, or when it is full and popping this cycle.
  - Otherwise S1 holds its entry.
- Occupancy = S1 valid + FIFO count, range 0..3.
- req_ready = !flush && (S1 valid + FIFO count) < 3. S1 never overwrites a held entry, and the FIFO never overflows.
- rsp_valid = FIFO count != 0. rsp_* drive the FIFO head.
- Fault priority:
  - req_addr[1:0] != 0 gives 01 (misaligned).
  - Otherwise req_addr[31:2] >= DEPTH gives 10 (out of range).
  - Any fault sets instruction = NOP_INSTR and performs no array access.
- Write port:
  - wr_en with wr_addr[1:0] == 0 and wr_addr[31:2] < DEPTH writes wr_data at the rising edge.
  - Any other wr_en writes nothing and pulses wr_err for exactly one cycle.
  - Writes are independent of the req/rsp handshake and of flush.
- Read-during-write to the same word at the same edge: S1 captures the OLD contents (read-before-write). The next fetch sees the new word.
- Flush:
  - Synchronous. At the edge with flush=1, S1 valid and the FIFO count are cleared.
  - No request is accepted in the flush cycle.
  - Any pop in that cycle is still consumed by the downstream stage, but nothing survives the flush.
- Pop and push in the same cycle with the FIFO full: both occur and the count stays 2.

## Timing
- Reset values (asynchronous, while reset_n=0):
  - req_ready=0, rsp_valid=0, rsp_instruction=0, rsp_addr=0, rsp_fault=0, wr_err=0.
  - S1 and the FIFO are empty.
- The first edge with reset_n=1 makes req_ready=1.
- Latency: a request accepted at edge E is at the FIFO head (rsp_valid=1) after edge E+1 when the FIFO is not backed up, i.e. 2 cycles from request to response.
- Throughput: 1 fetch/cycle sustained while rsp_ready=1.
- With rsp_ready=0 from empty, exactly 3 requests are accepted, then req_ready=0.
  - req_ready returns 1 in the cycle after the first pop frees a slot.
- Responses are delivered in request order and none are duplicated.
- wr_err is asserted in the cycle after the offending wr_en edge and lasts one cycle.
- reset_n deasserted mid-stream drops all in-flight fetches. The array keeps its contents.

## Test plan
- Load array[0..3] = 0x2BC00093, 0x01809113, 0x00012193, 0x00013213 via the write port, then fetch 0x0,0x4,0x8,0xC back-to-back with rsp_ready=1 -> same 4 words in order, rsp_valid from cycle 2, no gaps, rsp_fault=00.
- Fetch 0x2 -> rsp_fault=01, instruction 0x00000013. Fetch 0x2000 with DEPTH=2048 -> rsp_fault=10, instruction 0x00000013. Fetch 0x2002 -> 01.
- rsp_ready=0 while issuing 5 requests -> 3 accepted, req_ready=0. Then raise rsp_ready -> 3 responses in order, then the remaining 2 accepted.
- 3 entries in flight, assert flush for one cycle with req_valid=1 -> rsp_valid=0 next cycle, nothing returned, request at 0x40 accepted after flush drops and returns the word at 0x40.
- Write 0xDEADBEEF to 0x10 at the same edge a fetch of 0x10 is accepted -> returns the old word. A following fetch returns 0xDEADBEEF. Write to 0x11 -> wr_err one-cycle pulse, memory unchanged.
- Assert reset_n=0 with 2 responses buffered -> all outputs 0 immediately. After release, fetch 0x10 -> 0xDEADBEEF, showing contents are retained.
